shift_rotate_unit: RTL

//  Parametrised, pipelined shift/rotate execution unit for the datapath ALU.

---
 rtl/sru_pkg.sv | 29 ++
 rtl/sru_stage.sv | 77 +++++++
 rtl/shift_rotate_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sru_pkg.sv
// Shared definitions for the shift/rotate unit: op_code values, the control
// word that travels down the pipe, and a ceil-log2 helper for sizing.
package sru_pkg;

  localparam int OP_BITS = 5;

  localparam logic [OP_BITS-1:0] OP_SHR  = 5'b00101;
  localparam logic [OP_BITS-1:0] OP_SHRA = 5'b00110;
  localparam logic [OP_BITS-1:0] OP_SHL  = 5'b00111;
  localparam logic [OP_BITS-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_BITS-1:0] OP_ROR  = 5'b01001;

  // Per-slot control bits carried alongside the data through every stage.
  typedef struct packed {
    logic valid;    // slot holds a real op (bubbles have valid = 0)
    logic rot;      // rotate: the mask never shrinks
    logic left;     // data was bit-reversed on entry and must be reversed back
    logic illegal;  // op_code was not one of the five ops
  } sru_ctl_t;

  // Ceil-log2, usable in constant expressions.
  function automatic int log2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/sru_stage.sv
// One log-shifter level: right rotate-with-mask by 2^LEVEL when the matching
// count bit is set. REGISTERED selects a pipeline register on the output.
module sru_stage
  import sru_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int LEVEL      = 0,
  parameter bit REGISTERED = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  sru_ctl_t               i_ctl,
  input  logic [WIDTH-1:0]       i_data,
  input  logic [WIDTH-1:0]       i_mask,
  input  logic [log2(WIDTH)-1:0] i_cnt,
  input  logic                   i_fill,
  input  logic                   i_carry,
  output sru_ctl_t               o_ctl,
  output logic [WIDTH-1:0]       o_data,
  output logic [WIDTH-1:0]       o_mask,
  output logic [log2(WIDTH)-1:0] o_cnt,
  output logic                   o_fill,
  output logic                   o_carry
);

  localparam int SHIFT = 1 << LEVEL;

  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_mask;

  // Rotate data right by SHIFT; for shifts the mask of surviving bits shrinks too.
  always_comb begin
    w_data = i_data;
    w_mask = i_mask;
    if (i_cnt[LEVEL]) begin
      w_data = {i_data[SHIFT-1:0], i_data[WIDTH-1:SHIFT]};
      if (!i_ctl.rot) w_mask = i_mask >> SHIFT;
    end
  end

  if (REGISTERED) begin : g_reg
    // Pipeline register: the whole pipe moves together on the global enable.
    always_ff @(posedge i_clk) begin
      // NOTE: datapath fields are cleared along with valid so the unit's
      // outputs read all-zero after Clear rather than stale data.
      if (!i_rst_n) begin
        o_ctl   <= '0;
        o_data  <= '0;
        o_mask  <= '0;
        o_cnt   <= '0;
        o_fill  <= 1'b0;
        o_carry <= 1'b0;
      end else if (i_en) begin
        // NOTE: non-blocking so every stage samples its predecessor's old value.
        o_ctl   <= i_ctl;
        o_data  <= w_data;
        o_mask  <= w_mask;
        o_cnt   <= i_cnt;
        o_fill  <= i_fill;
        o_carry <= i_carry;
      end
    end
  end else begin : g_comb
    assign o_ctl   = i_ctl;
    assign o_data  = w_data;
    assign o_mask  = w_mask;
    assign o_cnt   = i_cnt;
    assign o_fill  = i_fill;
    assign o_carry = i_carry;

    // Clock, reset and enable only matter to the registered flavour.
    logic w_unused_ctrl;
    assign w_unused_ctrl = ^{i_clk, i_rst_n, i_en};
  end

endmodule

// File: rtl/shift_rotate_unit.sv
// Pipelined shift/rotate unit. Left ops are turned into right ops by bit
// reversal, so the core is a right-only log shifter with a fill mask.
module shift_rotate_unit
  import sru_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PIPE_REGS = 2
) (
  input  logic               Clock,
  input  logic               Clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_BITS-1:0] op_code,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [WIDTH-1:0]   amount,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carry,
  output logic               zero,
  output logic               illegal
);

  localparam int               LEVELS    = log2(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);

  function automatic logic [WIDTH-1:0] reverse_bits(input logic [WIDTH-1:0] value);
    for (int i = 0; i < WIDTH; i++) reverse_bits[i] = value[WIDTH-1-i];
  endfunction

  logic              w_en;
  logic              w_is_left;
  logic              w_is_rot;
  logic              w_is_legal;
  logic              w_sat;
  sru_ctl_t          w_p_ctl;
  logic [WIDTH-1:0]  w_p_data;
  logic [WIDTH-1:0]  w_p_mask;
  logic [LEVELS-1:0] w_p_cnt;
  logic              w_p_fill;
  logic              w_p_carry;

  sru_ctl_t          w_ctl   [LEVELS+1];
  logic [WIDTH-1:0]  w_data  [LEVELS+1];
  logic [WIDTH-1:0]  w_mask  [LEVELS+1];
  logic [LEVELS-1:0] w_cnt   [LEVELS+1];
  logic              w_fill  [LEVELS+1];
  logic              w_carry [LEVELS+1];
  logic [WIDTH-1:0]  w_merged;

  // A stalled output freezes the whole pipe, so input is accepted exactly when it moves.
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Prep: decode, saturate the count, pre-reverse left ops, pick fill and carry.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    w_p_mask  = '1;
    w_p_cnt   = '0;
    w_p_carry = 1'b0;

    w_is_left  = (op_code == OP_SHL) || (op_code == OP_ROL);
    w_is_rot   = (op_code == OP_ROL) || (op_code == OP_ROR);
    w_is_legal = w_is_left || w_is_rot || (op_code == OP_SHR) || (op_code == OP_SHRA);
    w_sat      = |amount[WIDTH-1:LEVELS];
    w_p_data   = w_is_left ? reverse_bits(data_in) : data_in;
    w_p_fill   = (op_code == OP_SHRA) && data_in[WIDTH-1];

    // In the (possibly reversed) right-shift frame the bit moved out last is
    // always data[count-1]; shifts of WIDTH or more empty the word entirely.
    if (w_is_legal) begin
      if (w_sat && !w_is_rot) begin
        w_p_mask  = '0;
        w_p_carry = (amount == WIDTH_VAL) ? w_p_data[WIDTH-1] : w_p_fill;
      end else begin
        w_p_cnt = amount[LEVELS-1:0];
        if (w_p_cnt != '0) w_p_carry = w_p_data[w_p_cnt - 1'b1];
      end
    end

    w_p_ctl.valid   = in_valid;
    w_p_ctl.rot     = w_is_rot;
    w_p_ctl.left    = w_is_left;
    w_p_ctl.illegal = in_valid && !w_is_legal;
  end

  assign w_ctl[0]   = w_p_ctl;
  assign w_data[0]  = w_p_data;
  assign w_mask[0]  = w_p_mask;
  assign w_cnt[0]   = w_p_cnt;
  assign w_fill[0]  = w_p_fill;
  assign w_carry[0] = w_p_carry;

  // Registers are spread so that exactly PIPE_REGS of the LEVELS stages are
  // registered, the last one always among them; latency then equals PIPE_REGS.
  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam bit REG_HERE = (((k + 1) * PIPE_REGS) / LEVELS) != ((k * PIPE_REGS) / LEVELS);

    sru_stage #(
      .WIDTH      (WIDTH),
      .LEVEL      (k),
      .REGISTERED (REG_HERE)
    ) u_stage (
      .i_clk   (Clock),
      .i_rst_n (Clear),
      .i_en    (w_en),
      .i_ctl   (w_ctl[k]),
      .i_data  (w_data[k]),
      .i_mask  (w_mask[k]),
      .i_cnt   (w_cnt[k]),
      .i_fill  (w_fill[k]),
      .i_carry (w_carry[k]),
      .o_ctl   (w_ctl[k+1]),
      .o_data  (w_data[k+1]),
      .o_mask  (w_mask[k+1]),
      .o_cnt   (w_cnt[k+1]),
      .o_fill  (w_fill[k+1]),
      .o_carry (w_carry[k+1])
    );
  end

  // Final stage: apply fill to vacated bits and undo the left-op reversal.
  always_comb begin
    w_merged = (w_data[LEVELS] & w_mask[LEVELS]) |
               ({WIDTH{w_fill[LEVELS]}} & ~w_mask[LEVELS]);
    result   = w_ctl[LEVELS].left ? reverse_bits(w_merged) : w_merged;
  end

  assign out_valid = w_ctl[LEVELS].valid;
  assign carry     = w_carry[LEVELS];
  assign illegal   = w_ctl[LEVELS].illegal;
  assign zero      = w_ctl[LEVELS].valid && (result == '0);

  // The count and rotate flag are fully consumed before the last stage.
  logic w_unused_tail;
  assign w_unused_tail = ^{w_cnt[LEVELS], w_ctl[LEVELS].rot};

endmodule
